audio_capture_buffer: RTL

Ping-pong capture buffer for the audio input path, the record-direction counterpart of the playback double buffer. Codec-side ADC samples are written into one bank of `DEPTH` words while the host-side bus reads the other, completed bank. At every bank swap the block raises a level interrupt to the host. It flags overrun when the host has not acknowledged the previous frame in time.

---
 rtl/audio_capture_buffer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/audio_capture_buffer.sv
// Ping-pong capture buffer: codec samples fill one bank while the host reads the other,
// with a level interrupt at every bank swap and a sticky overrun flag for missed acks.
module audio_capture_buffer #(
   parameter int DEPTH = 100,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] audio_in,
   input  logic             rd_en,
   input  logic [6:0]       rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             irq_ack,
   output logic             audio_irq
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [6:0] LAST_IDX    = 7'(DEPTH - 1);
   localparam logic [6:0] STATUS_ADDR = 7'(DEPTH);

   typedef enum logic [1:0] {
      SRC_ZERO,
      SRC_BANK,
      SRC_STATUS
   } rd_src_t;

   logic             wbank_reg, wbank_next;
   logic [6:0]       widx_reg, widx_next;
   logic             irq_reg, irq_next;
   logic             overrun_reg, overrun_next;
   logic [7:0]       frame_cnt_reg, frame_cnt_next;
   logic             frame_done;

   rd_src_t          rd_src_reg;
   logic             rbank_reg;
   logic [WIDTH-1:0] status_reg;
   logic [WIDTH-1:0] status_word;
   logic             rd_valid_reg;
   logic             rd_in_bank;

   assign frame_done = sample_valid && (widx_reg == LAST_IDX);
   assign rd_in_bank = rd_en && (rd_addr < STATUS_ADDR);

   // An ack in the same cycle as a completion retires the old frame first,
   // so the new frame raises irq without being counted as an overrun.
   always_comb begin
      wbank_next     = wbank_reg;
      widx_next      = widx_reg;
      irq_next       = irq_reg;
      overrun_next   = overrun_reg;
      frame_cnt_next = frame_cnt_reg;
      if (irq_ack) begin
         irq_next     = 1'b0;
         overrun_next = 1'b0;
      end
      if (sample_valid) begin
         if (frame_done) begin
            widx_next      = '0;
            wbank_next     = ~wbank_reg;
            irq_next       = 1'b1;
            frame_cnt_next = frame_cnt_reg + 8'd1;
            if (irq_reg && !irq_ack)
               overrun_next = 1'b1;
         end else begin
            widx_next = widx_reg + 7'd1;
         end
      end
   end

   always_comb begin
      status_word       = '0;
      status_word[15:8] = frame_cnt_reg;
      status_word[2]    = overrun_reg;
      status_word[1]    = ~wbank_reg;
      status_word[0]    = irq_reg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wbank_reg     <= 1'b0;
         widx_reg      <= '0;
         irq_reg       <= 1'b0;
         overrun_reg   <= 1'b0;
         frame_cnt_reg <= '0;
         rd_src_reg    <= SRC_ZERO;
         rbank_reg     <= 1'b0;
         status_reg    <= '0;
         rd_valid_reg  <= 1'b0;
      end else begin
         wbank_reg     <= wbank_next;
         widx_reg      <= widx_next;
         irq_reg       <= irq_next;
         overrun_reg   <= overrun_next;
         frame_cnt_reg <= frame_cnt_next;
         rd_valid_reg  <= rd_en;
         if (rd_en) begin
            if (rd_addr < STATUS_ADDR) begin
               rd_src_reg <= SRC_BANK;
               rbank_reg  <= ~wbank_reg;
            end else if (rd_addr == STATUS_ADDR) begin
               rd_src_reg <= SRC_STATUS;
               status_reg <= status_word;
            end else begin
               rd_src_reg <= SRC_ZERO;
            end
         end
      end
   end

   // Each bank is a simple dual-port RAM with its own registered read port.
   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic [WIDTH-1:0] mem [0:DEPTH-1];
      logic [WIDTH-1:0] q_reg;

      always_ff @(posedge clk) begin
         if (!reset && sample_valid && (wbank_reg == 1'(gi)))
            mem[widx_reg[AW-1:0]] <= audio_in;
      end

      always_ff @(posedge clk) begin
         if (reset)
            q_reg <= '0;
         else if (rd_in_bank)
            q_reg <= mem[rd_addr[AW-1:0]];
      end
   end

   always_comb begin
      rd_data = '0;
      case (rd_src_reg)
         SRC_BANK:   rd_data = rbank_reg ? g_bank[1].q_reg : g_bank[0].q_reg;
         SRC_STATUS: rd_data = status_reg;
         default:    rd_data = '0;
      endcase
   end

   assign rd_valid  = rd_valid_reg;
   assign audio_irq = irq_reg;

endmodule
